switch_debounce4: RTL and testbench

//   Upstream input stage for the combo logic. Takes WIDTH raw, asynchronous switch

---
 rtl/switch_debounce4_pkg.sv | 13 +
 rtl/switch_debounce4_if.sv | 27 ++
 rtl/switch_debounce4_debounce_bit.sv | 78 +++++++
 rtl/switch_debounce4.sv | 96 +++++++++
 tb/tb_switch_debounce4.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/switch_debounce4_pkg.sv
// Shared types and constants for the switch input stage and the combo logic.
package switch_debounce4_pkg;

  // Number of switch bits feeding the combo logic: {a,b,c,d}.
  localparam int unsigned COMBO_WIDTH = 4;

  // Per-bit debounce FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_t;

endpackage : switch_debounce4_pkg

// File: rtl/switch_debounce4_if.sv
// Switch input stage bus: raw levels in, debounced levels and status out.
interface switch_debounce4_if #(
  parameter int unsigned WIDTH = 4
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic             changed;
  logic             settled;

  // Producer of raw switch levels / consumer of clean levels.
  modport master (
    output sw_raw,
    input  sw_db,
    input  changed,
    input  settled
  );

  // Debouncer side.
  modport slave (
    input  sw_raw,
    output sw_db,
    output changed,
    output settled
  );

endinterface : switch_debounce4_if

// File: rtl/switch_debounce4_debounce_bit.sv
// Single-bit debouncer: accepts a new synchronised level only after it has
// persisted for DEBOUNCE_CYCLES consecutive clock edges.
module debounce_bit
  import switch_debounce4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic s,       // synchronised switch level
  input  logic init,    // level loaded at reset
  output logic level,   // debounced level, registered
  output logic strobe,  // high in the cycle before level takes a new value
  output logic busy     // a candidate level is being counted
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  db_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            strobe_d;

  // Next-state logic: count matching-mismatch cycles, reject any glitch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    strobe_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s != level_q) begin
          state_d = COUNT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      COUNT: begin
        if (s == level_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          level_d  = s;
          cnt_d    = '0;
          state_d  = IDLE;
          strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and accepted level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= init;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level  = level_q;
  assign strobe = strobe_d;
  assign busy   = (state_q == COUNT);

endmodule : debounce_bit

// File: rtl/switch_debounce4.sv
// Switch input stage: synchronises and debounces each raw switch bit and
// drives clean registered levels {a,b,c,d} into the combo logic, with a
// change pulse and a post-reset settled flag.
module switch_debounce4
  import switch_debounce4_pkg::*;
#(
  parameter int unsigned          WIDTH           = COMBO_WIDTH,
  parameter int unsigned          SYNC_STAGES     = 2,
  parameter int unsigned          DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0]     RESET_VALUE     = '0
) (
  input  logic               clk,
  input  logic               rst,
  switch_debounce4_if.slave  bus
);

  localparam int unsigned STARTUP_EDGES = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int unsigned SW            = $clog2(STARTUP_EDGES + 1);
  localparam logic [SW-1:0] STARTUP_LAST = SW'(STARTUP_EDGES);
  localparam logic [SW-1:0] STARTUP_ONE  = SW'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] strobe;
  logic [WIDTH-1:0] busy;

  logic             changed_q;
  logic [SW-1:0]    startup_q, startup_d;
  logic             settled_q, settled_d;

  // Multi-flop synchroniser per bit; sync_q[0] is the first stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= RESET_VALUE;
      end
    end else begin
      sync_q[0] <= bus.sw_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // One independent debouncer per switch bit.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .s     (sync_s[g]),
      .init  (RESET_VALUE[g]),
      .level (level[g]),
      .strobe(strobe[g]),
      .busy  (busy[g])
    );
  end

  // Change pulse lands in the same cycle the new levels become visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |strobe;
    end
  end

  // Saturating startup count and settled qualification.
  always_comb begin
    startup_d = startup_q;
    if (startup_q != STARTUP_LAST) begin
      startup_d = startup_q + STARTUP_ONE;
    end
    settled_d = (startup_d == STARTUP_LAST) && !(|busy);
  end

  // Startup counter and settled flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      startup_q <= '0;
      settled_q <= 1'b0;
    end else begin
      startup_q <= startup_d;
      settled_q <= settled_d;
    end
  end

  assign bus.sw_db   = level;
  assign bus.changed = changed_q;
  assign bus.settled = settled_q;

endmodule : switch_debounce4

// File: tb/tb_switch_debounce4.sv
// Scoreboard bench for switch_debounce4: stimulus pushes expected updates,
// a negedge monitor pops them whenever changed is seen.
module tb_switch_debounce4;

  typedef struct {
    logic [3:0]  val;
    int unsigned at_edge;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int unsigned compared;
  int unsigned mismatched;
  exp_t        exp_q[$];

  switch_debounce4_if #(.WIDTH(4)) bus ();

  switch_debounce4 #(
    .WIDTH          (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16),
    .RESET_VALUE    (4'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic combo(input logic [3:0] v);
    // v = {a,b,c,d}
    return ~((v[3] & v[2]) | (v[1] ^ v[0]));
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the negedge following clock edge n.
  task automatic wait_until(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Apply a raw value just after a rising edge; base is that edge's count.
  task automatic drive(input logic [3:0] v, output int unsigned base);
    @(posedge clk);
    #1;
    bus.sw_raw = v;
    base = cyc;
  endtask

  task automatic push(input logic [3:0] v, input int unsigned at);
    exp_t e;
    e.val = v;
    e.at_edge = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every changed pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (bus.changed === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_changed: got sw_db=%0h expected no update (cycle %0d)", bus.sw_db, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("update_value", bus.sw_db, e.val);
        chk("update_edge", cyc, e.at_edge);
      end
    end
  end

  initial begin
    int unsigned b, r;
    logic [3:0] prev;
    compared = 0;
    mismatched = 0;

    // Reset applied before any clock edge.
    rst = 1'b0;
    bus.sw_raw = 4'hF;
    #1 rst = 1'b1;
    #1;
    chk("reset_sw_db", bus.sw_db, 4'h0);
    chk("reset_changed", bus.changed, 0);
    chk("reset_settled", bus.settled, 0);

    bus.sw_raw = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    r = cyc;
    wait_until(r + 17);
    chk("settled_startup_low", bus.settled, 0);
    wait_until(r + 20);
    chk("settled_after_startup", bus.settled, 1);
    chk("sw_db_idle", bus.sw_db, 4'h0);

    // Held change reaches sw_db exactly at edge 18.
    drive(4'b1010, b);
    push(4'b1010, b + 18);
    wait_until(b + 17);
    chk("latency_edge17_db", bus.sw_db, 4'h0);
    chk("latency_edge17_changed", bus.changed, 0);
    wait_until(b + 18);
    chk("latency_edge18_db", bus.sw_db, 4'b1010);
    chk("latency_edge18_changed", bus.changed, 1);
    wait_until(b + 19);
    chk("changed_single_cycle", bus.changed, 0);
    chk("settled_after_update", bus.settled, 1);
    drive(4'h0, b);
    push(4'h0, b + 18);
    wait_until(b + 25);

    // Short pulses on bit 0 are rejected.
    drive(4'b0001, b);
    wait_until(b + 9);
    drive(4'h0, b);
    wait_until(b + 25);
    chk("glitch10_db", bus.sw_db, 4'h0);
    drive(4'b0001, b);
    wait_until(b + 14);
    drive(4'h0, b);
    wait_until(b + 25);
    chk("glitch15_db", bus.sw_db, 4'h0);

    // Staggered bits update independently, 5 edges apart.
    drive(4'b1000, b);
    push(4'b1000, b + 18);
    wait_until(b + 4);
    drive(4'b1010, b);
    push(4'b1010, b + 18);
    wait_until(b + 13);
    chk("stagger_first_db", bus.sw_db, 4'b1000);
    wait_until(b + 19);
    chk("stagger_second_db", bus.sw_db, 4'b1010);
    drive(4'h0, b);
    push(4'h0, b + 18);
    wait_until(b + 25);

    // Reset mid-count discards the pending count.
    drive(4'hF, b);
    wait_until(b + 10);
    rst = 1'b1;
    #1;
    chk("midreset_sw_db", bus.sw_db, 4'h0);
    chk("midreset_changed", bus.changed, 0);
    chk("midreset_settled", bus.settled, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    r = cyc;
    push(4'hF, r + 18);
    wait_until(r + 17);
    chk("postreset_edge17_db", bus.sw_db, 4'h0);
    chk("postreset_settled_low", bus.settled, 0);
    wait_until(r + 18);
    chk("postreset_edge18_db", bus.sw_db, 4'hF);
    wait_until(r + 20);
    chk("postreset_settled_high", bus.settled, 1);
    drive(4'h0, b);
    push(4'h0, b + 18);
    wait_until(b + 25);

    // Sweep every input value; combo output follows sw_db.
    prev = 4'h0;
    for (int v = 0; v < 16; v++) begin
      drive(4'(v), b);
      if (4'(v) != prev) push(4'(v), b + 18);
      prev = 4'(v);
      wait_until(b + 20);
      chk("sweep_db", bus.sw_db, v);
      chk("sweep_combo", combo(bus.sw_db), combo(4'(v)));
    end

    wait_until(cyc + 3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_switch_debounce4
